// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register ids,
// processor status encodings and the default data width.
package y86_pkg;
  localparam int XLEN = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_ALU    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    AOK = 2'b00,
    HLT = 2'b01,
    INS = 2'b10
  } stat_t;
endpackage

// File: rtl/y86_regfile.sv
// 15-entry architectural register file, two write ports (M beats E) and two
// combinational read ports. WB_BYPASS_EN forwards this cycle's writes to reads.
module y86_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            we_e_i,
  input  logic [3:0]      dst_e_i,
  input  logic [XLEN-1:0] val_e_i,
  input  logic            we_m_i,
  input  logic [3:0]      dst_m_i,
  input  logic [XLEN-1:0] val_m_i,
  input  logic [3:0]      src_a_i,
  input  logic [3:0]      src_b_i,
  output logic [XLEN-1:0] val_a_o,
  output logic [XLEN-1:0] val_b_o
);
  import y86_pkg::*;

  logic [XLEN-1:0] r_regs [15];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= XLEN'(i);
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (we_m_i && dst_m_i == 4'(i))      r_regs[i] <= val_m_i;
        else if (we_e_i && dst_e_i == 4'(i)) r_regs[i] <= val_e_i;
      end
    end
  end

  // Index 0xF never matches a stored entry, so it reads as zero.
  always_comb begin
    val_a_o = '0;
    val_b_o = '0;
    for (int i = 0; i < 15; i++) begin
      if (src_a_i == 4'(i)) val_a_o = r_regs[i];
      if (src_b_i == 4'(i)) val_b_o = r_regs[i];
    end
`ifdef WB_BYPASS_EN
    if (src_a_i != REG_NONE) begin
      if (we_m_i && dst_m_i == src_a_i)      val_a_o = val_m_i;
      else if (we_e_i && dst_e_i == src_a_i) val_a_o = val_e_i;
    end
    if (src_b_i != REG_NONE) begin
      if (we_m_i && dst_m_i == src_b_i)      val_b_o = val_m_i;
      else if (we_e_i && dst_e_i == src_b_i) val_b_o = val_e_i;
    end
`endif
  end
endmodule

// File: rtl/writeback.sv
// Y86-64 write-back: destination decode, status FSM, retired counter and the
// register file. Optional same-cycle read bypass via macro WB_BYPASS_EN.
module writeback #(
  parameter int XLEN  = y86_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [3:0]       icode_i,
  input  logic             cnd_i,
  input  logic [3:0]       rA_i,
  input  logic [3:0]       rB_i,
  input  logic [XLEN-1:0]  valE_i,
  input  logic [XLEN-1:0]  valM_i,
  input  logic [3:0]       srcA_i,
  input  logic [3:0]       srcB_i,
  output logic [XLEN-1:0]  valA_o,
  output logic [XLEN-1:0]  valB_o,
  output logic [1:0]       stat_o,
  output logic [CNT_W-1:0] retired_o
);
  import y86_pkg::*;

  stat_t            r_stat, w_stat_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             w_accept, w_invalid, w_we_e, w_we_m;
  logic [3:0]       w_dst_e, w_dst_m;

  assign w_accept  = valid_i && (r_stat == AOK);
  assign w_invalid = icode_i > I_POPL;

  always_comb begin
    w_dst_e = REG_NONE;
    w_dst_m = REG_NONE;
    case (icode_i)
      I_RRMOVL:                          w_dst_e = cnd_i ? rB_i : REG_NONE;
      I_IRMOVL, I_ALU:                   w_dst_e = rB_i;
      I_PUSHL, I_POPL, I_CALL, I_RET:    w_dst_e = REG_RSP;
      default:                           w_dst_e = REG_NONE;
    endcase
    if (icode_i == I_MRMOVL || icode_i == I_POPL) w_dst_m = rA_i;
  end

  // Invalid icodes decode to 0xF above; the explicit term keeps intent clear.
  assign w_we_e = w_accept && !w_invalid && (w_dst_e != REG_NONE);
  assign w_we_m = w_accept && !w_invalid && (w_dst_m != REG_NONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_stat <= AOK;
    else          r_stat <= w_stat_nxt;
  end

  always_comb begin
    w_stat_nxt = r_stat;
    if (w_accept) begin
      if (w_invalid)                w_stat_nxt = INS;
      else if (icode_i == I_HALT)   w_stat_nxt = HLT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                          r_retired <= '0;
    else if (w_accept && r_retired != '1)  r_retired <= r_retired + 1'b1;
  end

  assign stat_o    = r_stat;
  assign retired_o = r_retired;

  y86_regfile #(.XLEN(XLEN)) u_rf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_e_i  (w_we_e),
    .dst_e_i (w_dst_e),
    .val_e_i (valE_i),
    .we_m_i  (w_we_m),
    .dst_m_i (w_dst_m),
    .val_m_i (valM_i),
    .src_a_i (srcA_i),
    .src_b_i (srcB_i),
    .val_a_o (valA_o),
    .val_b_o (valB_o)
  );
endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: driver pushes expected read/status values
// from a behavioural model; a negedge monitor pops and compares.
module tb_writeback;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [3:0]       icode_i = '0;
  logic             cnd_i = 1'b0;
  logic [3:0]       rA_i = 4'hF, rB_i = 4'hF;
  logic [XLEN-1:0]  valE_i = '0, valM_i = '0;
  logic [3:0]       srcA_i = 4'hF, srcB_i = 4'hF;
  logic [XLEN-1:0]  valA_o, valB_o;
  logic [1:0]       stat_o;
  logic [CNT_W-1:0] retired_o;

  writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .icode_i(icode_i),
    .cnd_i(cnd_i), .rA_i(rA_i), .rB_i(rB_i), .valE_i(valE_i), .valM_i(valM_i),
    .srcA_i(srcA_i), .srcB_i(srcB_i), .valA_o(valA_o), .valB_o(valB_o),
    .stat_o(stat_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      st;
    int              ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: architectural registers, status, retired count.
  logic [XLEN-1:0] m_reg [15];
  logic [1:0]      m_stat;
  int              m_ret;

  function automatic void check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = XLEN'(i);
    m_stat = 2'b00;
    m_ret  = 0;
  endfunction

  // Destinations straight from the ISA table; 15 means no write.
  function automatic int dst_e(logic [3:0] ic, logic c, logic [3:0] rb);
    if (ic == 2) return c ? int'(rb) : 15;
    if (ic == 3 || ic == 6) return int'(rb);
    if (ic == 8 || ic == 9 || ic == 10 || ic == 11) return 4;
    return 15;
  endfunction

  function automatic int dst_m(logic [3:0] ic, logic [3:0] ra);
    if (ic == 5 || ic == 11) return int'(ra);
    return 15;
  endfunction

  task automatic issue(input logic v, input logic [3:0] ic, input logic c,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [XLEN-1:0] ve, input logic [XLEN-1:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    exp_t e;
    bit   acc;
    int   de, dm;
    @(posedge clk_i); #1;
    valid_i = v; icode_i = ic; cnd_i = c; rA_i = ra; rB_i = rb;
    valE_i = ve; valM_i = vm; srcA_i = sa; srcB_i = sb;
    acc = v && (m_stat == 2'b00);
    de  = (ic > 11) ? 15 : dst_e(ic, c, rb);
    dm  = (ic > 11) ? 15 : dst_m(ic, ra);
    e.a = (sa == 15) ? '0 : m_reg[sa];
    e.b = (sb == 15) ? '0 : m_reg[sb];
`ifdef WB_BYPASS_EN
    if (acc && sa != 15) begin
      if (dm == int'(sa)) e.a = vm; else if (de == int'(sa)) e.a = ve;
    end
    if (acc && sb != 15) begin
      if (dm == int'(sb)) e.b = vm; else if (de == int'(sb)) e.b = ve;
    end
`endif
    e.st  = m_stat;
    e.ret = m_ret;
    exp_q.push_back(e);
    if (acc) begin
      if (ic > 11) m_stat = 2'b10;
      else if (ic == 0) m_stat = 2'b01;
      else begin
        if (de != 15) m_reg[de] = ve;
        if (dm != 15) m_reg[dm] = vm;
      end
      m_ret = (m_ret == (1 << CNT_W) - 1) ? m_ret : m_ret + 1;
    end
  endtask

  // Reset lands mid-cycle with a write pending; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk_i); #1;
    valid_i = 1'b1; icode_i = 4'h3; rB_i = 4'h2; valE_i = 64'hDEAD;
    srcA_i = 4'h3; srcB_i = 4'hF;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check("rst_stat", XLEN'(stat_o), 0);
    check("rst_retired", XLEN'(retired_o), 0);
    check("rst_valA", valA_o, 3);
    check("rst_valB", valB_o, 0);
    repeat (2) @(negedge clk_i);
    valid_i = 1'b0;
    rst_n_i = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valA", valA_o, e.a);
      check("valB", valB_o, e.b);
      check("stat", XLEN'(stat_o), XLEN'(e.st));
      check("retired", XLEN'(retired_o), XLEN'(e.ret));
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk_i); n++;
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h3, 4'hF);
    issue(1, 4'h3, 0, 4'hF, 4'h2, 64'h1234, 0, 4'h2, 4'hF);
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h2, 4'h5);
    issue(1, 4'h2, 0, 4'h3, 4'h5, 64'hAA, 0, 4'h5, 4'h2);
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h5, 4'hF);
    issue(1, 4'h2, 1, 4'h3, 4'h5, 64'hAA, 0, 4'h5, 4'h4);
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h5, 4'h4);
    issue(1, 4'hB, 0, 4'h4, 4'hF, 64'h100, 64'h77, 4'h4, 4'hF);
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h4, 4'h1);
    issue(1, 4'h0, 0, 4'hF, 4'hF, 0, 0, 4'h1, 4'hF);
    issue(1, 4'h6, 0, 4'hF, 4'h1, 64'h9, 0, 4'h1, 4'hF);
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h1, 4'hF);
    drain();
    do_reset();
    issue(1, 4'hC, 0, 4'h2, 4'h3, 64'h55, 64'h66, 4'h3, 4'h2);
    issue(1, 4'h6, 0, 4'hF, 4'h3, 64'h55, 0, 4'h3, 4'h2);
    issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h3, 4'h2);
    drain();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      issue(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h2, 4'hF);
      for (int k = 0; k < 120; k++) begin
        int p;
        logic [3:0] ic;
        p  = $urandom_range(0, 199);
        ic = (p < 2) ? 4'h0 : (p < 4) ? 4'(12 + $urandom_range(0, 3))
                                      : 4'($urandom_range(1, 11));
        issue(1'($urandom_range(0, 3) != 0), ic, 1'($urandom),
              4'($urandom), 4'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom), 4'($urandom));
      end
      drain();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
